// File: rtl/fence_t_seq.sv
// fence_t_seq: fence.t flush / microreset sequencer with padding-based timing ceiling.
module fence_t_seq #(
  parameter int unsigned NrCh      = 2,
  parameter int unsigned RstCycles = 16,
  parameter int unsigned InitHold  = 3,
  parameter int unsigned PadWidth  = 32,
  parameter int unsigned VLEN      = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                fence_t_i,
  input  logic [NrCh-1:0]     ch_mask_i,
  input  logic [VLEN-1:0]     pc_commit_i,
  input  logic [VLEN-1:0]     boot_addr_i,
  output logic [VLEN-1:0]     rst_addr_o,
  output logic [NrCh-1:0]     flush_req_o,
  input  logic [NrCh-1:0]     flush_ack_i,
  input  logic [NrCh-1:0]     busy_i,
  input  logic [PadWidth-1:0] pad_i,
  input  logic                src_sel_i,
  input  logic                time_irq_i,
  input  logic [1:0]          priv_lvl_i,
  output logic                halt_o,
  output logic                rst_uarch_no,
  output logic                cache_init_no,
  output logic [PadWidth-1:0] ceil_o,
  output logic                done_o
);
  localparam int unsigned CntW = $clog2(RstCycles);
  typedef enum logic [1:0] {IDLE, FLUSH, WAIT, RST} state_e;
  state_e state_q, state_d;
  logic [NrCh-1:0] mask_q, ack_q, ack_now;
  logic [VLEN-1:0] rst_addr_q;
  logic addr_vld_q;
  logic [PadWidth-1:0] pad_cnt;
  logic [1:0] priv_q;
  logic time_irq_q;
  logic [CntW-1:0] rst_cnt;
  logic [InitHold-1:0] init_sr;
  logic all_ack, busy_m, rst_last, pad_load;
  assign ack_now = flush_ack_i & mask_q;
  assign all_ack = &(ack_q | ack_now | ~mask_q);
  assign busy_m = |(busy_i & mask_q);
  assign rst_last = rst_cnt == CntW'(RstCycles - 1);
  assign pad_load = src_sel_i ? (priv_q != 2'b00 && priv_lvl_i == 2'b00) : (time_irq_i & ~time_irq_q);
  // boot_addr_i shows through until the first fence.t captures a resume address
  assign rst_addr_o = addr_vld_q ? rst_addr_q : boot_addr_i;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = fence_t_i ? FLUSH : IDLE;
      FLUSH:   state_d = all_ack ? WAIT : FLUSH;
      WAIT:    state_d = (!busy_m && pad_cnt == '0) ? RST : WAIT;
      RST:     state_d = rst_last ? IDLE : RST;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    halt_o = state_q != IDLE;
    rst_uarch_no = state_q != RST;
    cache_init_no = state_q == RST || |init_sr;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_q <= '0;
      ack_q <= '0;
      flush_req_o <= '0;
      rst_addr_q <= '0;
      addr_vld_q <= 1'b0;
      pad_cnt <= '0;
      priv_q <= 2'b11;
      time_irq_q <= 1'b0;
      rst_cnt <= '0;
      init_sr <= '0;
      ceil_o <= '0;
      done_o <= 1'b0;
    end else begin
      priv_q <= priv_lvl_i;
      time_irq_q <= time_irq_i;
      pad_cnt <= pad_load ? pad_i : pad_cnt - PadWidth'(pad_cnt != '0);
      rst_cnt <= (state_q == RST && !rst_last) ? rst_cnt + 1'b1 : '0;
      init_sr <= InitHold'({init_sr, state_q == RST});
      done_o <= state_q == RST && rst_last;
      if (state_q == IDLE && fence_t_i) begin
        mask_q <= ch_mask_i;
        ack_q <= '0;
        flush_req_o <= ch_mask_i;
        rst_addr_q <= pc_commit_i + VLEN'(4);
        addr_vld_q <= 1'b1;
      end
      if (state_q == FLUSH) begin
        ack_q <= ack_q | ack_now;
        flush_req_o <= mask_q & ~(ack_q | ack_now);
        if (all_ack) ceil_o <= (pad_cnt == '0) ? '0 : pad_i - pad_cnt;
      end
    end
  end
endmodule

// File: tb/tb_fence_t_seq.sv
// tb_fence_t_seq: directed bench; resume address and ceiling are scoreboarded against done_o.
module tb_fence_t_seq;
  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic fence_t_i = 1'b0;
  logic [1:0] ch_mask_i = '0, flush_req_o, flush_ack_i = '0, busy_i = '0;
  logic [63:0] pc_commit_i = '0, boot_addr_i = 64'h1234_0000, rst_addr_o;
  logic [31:0] pad_i = '0, ceil_o;
  logic src_sel_i = 1'b0, time_irq_i = 1'b0;
  logic [1:0] priv_lvl_i = 2'b11;
  logic halt_o, rst_uarch_no, cache_init_no, done_o;
  typedef struct {logic [63:0] addr; logic [31:0] ceil;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;
  int cnt_rst = 0, cnt_init = 0, cnt_done = 0;
  fence_t_seq dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .fence_t_i(fence_t_i), .ch_mask_i(ch_mask_i),
    .pc_commit_i(pc_commit_i), .boot_addr_i(boot_addr_i), .rst_addr_o(rst_addr_o),
    .flush_req_o(flush_req_o), .flush_ack_i(flush_ack_i), .busy_i(busy_i), .pad_i(pad_i),
    .src_sel_i(src_sel_i), .time_irq_i(time_irq_i), .priv_lvl_i(priv_lvl_i), .halt_o(halt_o),
    .rst_uarch_no(rst_uarch_no), .cache_init_no(cache_init_no), .ceil_o(ceil_o), .done_o(done_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk_i);
    #1;
  endtask
  task automatic fence(input logic [1:0] m, input logic [63:0] pc);
    fence_t_i = 1'b1;
    ch_mask_i = m;
    pc_commit_i = pc;
    step;
    fence_t_i = 1'b0;
  endtask
  task automatic ack(input logic [1:0] a);
    flush_ack_i = a;
    step;
    flush_ack_i = '0;
  endtask
  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      step;
      seen = done_o;
    end
    chk(tag, seen, 1'b1);
  endtask
  task automatic clr;
    cnt_rst = 0;
    cnt_init = 0;
    cnt_done = 0;
  endtask
  always @(negedge clk_i) begin
    logic ok;
    exp_t e;
    if (rst_ni) begin
      cnt_rst += int'(!rst_uarch_no);
      cnt_init += int'(cache_init_no);
      if (done_o) begin
        cnt_done++;
        ok = sb.size() != 0;
        chk("sb_pop", ok, 1'b1);
        if (ok) begin
          e = sb.pop_front();
          chk("sb_rst_addr", rst_addr_o, e.addr);
          chk("sb_ceil", ceil_o, e.ceil);
        end
      end
    end
  end
  initial begin
    int n;
    repeat (3) step;
    chk("rst_halt", halt_o, 0);
    chk("rst_uarch", rst_uarch_no, 1);
    chk("rst_cinit", cache_init_no, 0);
    chk("rst_req", flush_req_o, 0);
    chk("rst_ceil", ceil_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_addr", rst_addr_o, 64'h1234_0000);
    rst_ni = 1'b1;
    step;
    // two channels, staggered acks
    clr;
    fence(2'b11, 64'h8000_0000);
    chk("t1_req0", flush_req_o, 2'b11);
    chk("t1_halt", halt_o, 1);
    step;
    step;
    ack(2'b01);
    chk("t1_req1", flush_req_o, 2'b10);
    repeat (3) step;
    chk("t1_req1b", flush_req_o, 2'b10);
    sb.push_back('{64'h8000_0004, 32'd0});
    ack(2'b10);
    chk("t1_req2", flush_req_o, 2'b00);
    chk("t1_wait", rst_uarch_no, 1);
    step;
    chk("t1_rst", rst_uarch_no, 0);
    wait_done("t1_done");
    repeat (5) step;
    chk("t1_rstcyc", cnt_rst, 16);
    chk("t1_initcyc", cnt_init, 19);
    chk("t1_ndone", cnt_done, 1);
    chk("t1_addr", rst_addr_o, 64'h8000_0004);
    chk("t1_halt_off", halt_o, 0);
    // unmasked ack and busy ignored
    clr;
    busy_i = 2'b10;
    fence(2'b01, 64'h2000);
    ack(2'b10);
    chk("t2_req", flush_req_o, 2'b01);
    chk("t2_flush", halt_o, 1);
    sb.push_back('{64'h2004, 32'd0});
    ack(2'b01);
    chk("t2_req0", flush_req_o, 2'b00);
    chk("t2_wait", rst_uarch_no, 1);
    step;
    chk("t2_rst", rst_uarch_no, 0);
    wait_done("t2_done");
    busy_i = '0;
    repeat (5) step;
    // timer-irq padding
    clr;
    pad_i = 32'd100;
    fence(2'b01, 64'h5000);
    time_irq_i = 1'b1;
    step;
    repeat (30) step;
    sb.push_back('{64'h5004, 32'd30});
    ack(2'b01);
    n = 0;
    while (rst_uarch_no && n < 500) begin
      step;
      n++;
    end
    chk("t3_waitlen", n, 70);
    time_irq_i = 1'b0;
    wait_done("t3_done");
    repeat (5) step;
    // privilege-drop padding with restart
    clr;
    src_sel_i = 1'b1;
    pad_i = 32'd10;
    fence(2'b01, 64'h6000);
    priv_lvl_i = 2'b00;
    step;
    repeat (3) step;
    priv_lvl_i = 2'b11;
    step;
    priv_lvl_i = 2'b00;
    step;
    step;
    step;
    sb.push_back('{64'h6004, 32'd2});
    ack(2'b01);
    priv_lvl_i = 2'b11;
    wait_done("t4_done");
    src_sel_i = 1'b0;
    repeat (5) step;
    // empty mask; fence during RST ignored
    clr;
    sb.push_back('{64'h3004, 32'd0});
    fence(2'b00, 64'h3000);
    chk("t5_flush", rst_uarch_no, 1);
    step;
    chk("t5_wait", rst_uarch_no, 1);
    chk("t5_wait_halt", halt_o, 1);
    step;
    chk("t5_rst", rst_uarch_no, 0);
    fence(2'b11, 64'h1000);
    wait_done("t5_done");
    repeat (5) step;
    chk("t5_ndone", cnt_done, 1);
    chk("t5_addr", rst_addr_o, 64'h3004);
    chk("t5_req", flush_req_o, 2'b00);
    chk("t5_idle", halt_o, 0);
    // async reset mid-RST
    fence(2'b00, 64'h4000);
    step;
    step;
    step;
    chk("t6_inrst", rst_uarch_no, 0);
    #2 rst_ni = 1'b0;
    #1;
    chk("t6_uarch", rst_uarch_no, 1);
    chk("t6_halt", halt_o, 0);
    chk("t6_addr", rst_addr_o, 64'h1234_0000);
    chk("t6_cinit", cache_init_no, 0);
    chk("t6_done", done_o, 0);
    step;
    rst_ni = 1'b1;
    repeat (3) step;
    chk("t6_idle", halt_o, 0);
    chk("sb_left", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fence_t_seq.md
Name: fence_t_seq

Overview:
- Parametrised fence.t / microarchitectural-reset sequencer. It is the successor to the single-dcache flush-and-reset FSM in the core controller.
- Supports N flush channels with independent request/ack/busy handshakes and a per-fence channel mask.
- Supports configurable microreset and cache-init hold lengths, and a selectable padding-trigger source.
- Sits beside the flush controller; drives halt, microreset and cache-init-inhibit for the core.

Parameters:
- NrCh, 2, number of flush channels (e.g. 0 = dcache, 1 = icache/L1 others); 1..8.
- RstCycles, 16, cycles rst_uarch_no held low; 2..256.
- InitHold, 3, cycles cache_init_no stays high after leaving RST; 1..8.
- PadWidth, 32, width of padding counter and ceiling.
- VLEN, 64, address width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- fence_t_i  in  1  fence.t commit pulse.
- ch_mask_i  in  NrCh  channels to flush for this fence; sampled with fence_t_i.
- pc_commit_i  in  VLEN  PC of committing fence.t.
- boot_addr_i  in  VLEN  reset value of rst_addr_o.
- rst_addr_o  out  VLEN  resume address after microreset.
- flush_req_o  out  NrCh  per-channel flush request (registered).
- flush_ack_i  in  NrCh  per-channel flush-done pulse.
- busy_i  in  NrCh  per-channel outstanding external transaction.
- pad_i  in  PadWidth  padding length (CSR).
- src_sel_i  in  1  pad trigger source: 0 = time irq rising edge, 1 = priv drop from S/M to U.
- time_irq_i  in  1  timer interrupt.
- priv_lvl_i  in  2  current privilege level.
- halt_o  out  1  halt commit.
- rst_uarch_no  out  1  microreset, active-low.
- cache_init_no  out  1  suppress cache init.
- ceil_o  out  PadWidth  registered residual-pad ceiling.
- done_o  out  1  one-cycle pulse on return to IDLE.

Behaviour:
- Reset values:
  - state IDLE; flush_req_o = 0; halt_o = 0; rst_uarch_no = 1; cache_init_no = 0.
  - ceil_o = 0; done_o = 0; rst_addr_o = boot_addr_i; pad counter = 0.
  - priv_q = M; time_irq_q = 0.
- FSM IDLE → FLUSH → WAIT → RST → IDLE. halt_o = (state != IDLE), combinational.
- IDLE:
  - On fence_t_i: capture mask_q = ch_mask_i; rst_addr_q = pc_commit_i + 4 (mod 2^VLEN); clear ack_q.
  - Set flush_req_o = ch_mask_i next cycle; go to FLUSH.
- FLUSH:
  - ack_q[i] is set on flush_ack_i[i] & mask_q[i] and is sticky.
  - flush_req_o[i] deasserts the cycle after its ack is captured.
  - Acks on unmasked channels are ignored.
  - When (ack_q | ack_now | ~mask_q) is all ones: register ceil_o = (pad_cnt == 0) ? 0 : pad_i - pad_cnt, using the pad_cnt value of that cycle, then go to WAIT.
  - mask = 0 leaves FLUSH after exactly 1 cycle.
- WAIT:
  - Go to RST when no masked channel has busy_i set and pad_cnt == 0.
  - Unmasked busy_i is ignored.
- RST:
  - rst_uarch_no = 0 for exactly RstCycles cycles; the counter is $clog2(RstCycles) wide and cleared on exit.
  - cache_init_no = 1 during RST and for InitHold cycles after. Implement as a shift register fed by (state == RST).
  - Go to IDLE; done_o pulses in the first IDLE cycle.
- Pad counter:
  - Load event: src_sel_i ? (priv_q != U && priv_lvl_i == U) : (time_irq_i & ~time_irq_q).
  - On a load event, counter = pad_i (load has priority over decrement).
  - Otherwise it decrements while nonzero and saturates at 0.
  - The counter runs in all states.
- ceil_o holds its value until the next FLUSH exit.
- fence_t_i outside IDLE is ignored: no re-capture of mask or rst_addr.
- rst_addr_o keeps its value across microreset; only rst_ni restores boot_addr_i.
- Async reset mid-sequence returns everything to the reset values above within the reset; there are no partial outputs.

Test Plan:
- NrCh = 2, mask = 2'b11, pc = 0x8000_0000:
  - ack0 at +3 and ack1 at +7 → flush_req_o = 2'b11 then 2'b10 then 2'b00.
  - WAIT entered at +8; rst_uarch_no low for 16 cycles; cache_init_no high for 19 cycles.
  - rst_addr_o = 0x8000_0004; done_o pulses once.
- mask = 2'b01 with busy_i = 2'b10 held, ack1 pulsed → ack1 ignored, busy1 ignored; RST entered 1 cycle after ack0.
- pad_i = 100, src_sel = 0, time irq rising 30 cycles before the final ack → ceil_o = 30; WAIT lasts about 70 cycles until pad_cnt = 0.
- src_sel = 1: priv M→U loads pad = 10; U→U produces no load; a second load while counting restarts at 10 → ceil_o reflects the restarted value.
- fence_t_i re-asserted during RST with pc = 0x1000 → ignored: rst_addr_o unchanged, a single done_o.
- mask = 0 and pad_cnt = 0 → FLUSH 1 cycle, WAIT 1 cycle, then RST; ceil_o = 0. Assert rst_ni mid-RST → rst_uarch_no = 1, halt_o = 0, rst_addr_o = boot_addr_i.
